// File: rtl/match_controller.sv
// Match/round sequencer: tracks lives and saturating kill scores per tank and
// drives the freeze (game_over) and respawn controls for the engine.
module match_controller #(
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned LIFE_W        = 2,
    parameter int unsigned SCORE_W       = 8,
    parameter int unsigned COUNTDOWN_CYC = 50_000_000,
    parameter int unsigned ROUND_END_CYC = 25_000_000,
    localparam int unsigned ID_W = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           game_on,
    input  logic [NUM_PLAYERS-1:0]         hit,
    input  logic [NUM_PLAYERS*ID_W-1:0]    hit_by,
    output logic                           game_over,
    output logic [NUM_PLAYERS-1:0]         respawn,
    output logic [NUM_PLAYERS-1:0]         alive,
    output logic [NUM_PLAYERS*LIFE_W-1:0]  lives,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic [2:0]                     state,
    output logic [ID_W-1:0]                winner,
    output logic                           winner_valid,
    output logic                           draw
);

    localparam int unsigned MAX_CYC = (COUNTDOWN_CYC > ROUND_END_CYC) ? COUNTDOWN_CYC : ROUND_END_CYC;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned CNT_W   = $clog2(NUM_PLAYERS + 1);
    localparam int unsigned SUM_W   = SCORE_W + CNT_W;

    localparam logic [TMR_W-1:0]   CD_LAST    = TMR_W'(COUNTDOWN_CYC - 1);
    localparam logic [TMR_W-1:0]   RE_LAST    = TMR_W'(ROUND_END_CYC - 1);
    localparam logic [LIFE_W-1:0]  LIVES_INIT = LIFE_W'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_COUNTDOWN  = 3'd1,
        S_PLAY       = 3'd2,
        S_ROUND_END  = 3'd3,
        S_MATCH_OVER = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [LIFE_W-1:0]      lives_q [NUM_PLAYERS];
    logic [LIFE_W-1:0]      lives_d [NUM_PLAYERS];
    logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
    logic [SCORE_W-1:0]     score_d [NUM_PLAYERS];
    logic [SCORE_W-1:0]     score_hit [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] respawn_q, respawn_d;
    logic [NUM_PLAYERS-1:0] alive_q, alive_d;
    logic                   game_over_q, game_over_d;
    logic [ID_W-1:0]        winner_q, winner_d;
    logic                   winner_valid_q, winner_valid_d;
    logic                   draw_q, draw_d;

    logic [NUM_PLAYERS-1:0] alive_now;
    logic [NUM_PLAYERS-1:0] qual;
    logic [CNT_W-1:0]       n_alive;
    logic [ID_W-1:0]        last_idx;

    always_comb begin : alive_summary
        n_alive  = '0;
        last_idx = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            alive_now[i] = (lives_q[i] != '0);
            qual[i]      = hit[i] && alive_now[i];
            if (alive_now[i]) begin
                n_alive  = n_alive + CNT_W'(1);
                last_idx = ID_W'(i);
            end
        end
    end

    // Attacker liveness uses pre-hit lives so mutual same-cycle kills both score.
    always_comb begin : kill_scoring
        logic [CNT_W-1:0] kills;
        logic [SUM_W-1:0] sum;
        kills = '0;
        sum   = '0;
        for (int unsigned a = 0; a < NUM_PLAYERS; a++) begin
            kills = '0;
            for (int unsigned v = 0; v < NUM_PLAYERS; v++) begin
                if (qual[v] && (v != a) && alive_now[a] &&
                    (hit_by[v*ID_W +: ID_W] == ID_W'(a))) begin
                    kills = kills + CNT_W'(1);
                end
            end
            sum          = SUM_W'(score_q[a]) + SUM_W'(kills);
            score_hit[a] = (sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
        end
    end

    always_comb begin : next_state
        state_d        = state_q;
        timer_d        = timer_q;
        lives_d        = lives_q;
        score_d        = score_q;
        respawn_d      = '0;
        winner_d       = winner_q;
        winner_valid_d = winner_valid_q;
        draw_d         = draw_q;

        case (state_q)
            S_IDLE: begin
                if (game_on) begin
                    state_d   = S_COUNTDOWN;
                    timer_d   = '0;
                    respawn_d = '1;
                    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                        lives_d[i] = LIVES_INIT;
                        score_d[i] = '0;
                    end
                end
            end
            S_COUNTDOWN: begin
                if (!game_on) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q == CD_LAST) begin
                    state_d = S_PLAY;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_PLAY: begin
                if (!game_on) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (|qual) begin
                    state_d = S_ROUND_END;
                    timer_d = '0;
                    score_d = score_hit;
                    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                        if (qual[i]) lives_d[i] = lives_q[i] - LIFE_W'(1);
                    end
                end
            end
            S_ROUND_END: begin
                if (!game_on) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q == RE_LAST) begin
                    timer_d = '0;
                    if (n_alive >= CNT_W'(2)) begin
                        state_d   = S_COUNTDOWN;
                        respawn_d = alive_now;
                    end else begin
                        state_d = S_MATCH_OVER;
                        if (n_alive == CNT_W'(1)) begin
                            winner_d       = last_idx;
                            winner_valid_d = 1'b1;
                        end else begin
                            draw_d = 1'b1;
                        end
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_MATCH_OVER: begin
                if (!game_on) begin
                    state_d        = S_IDLE;
                    winner_valid_d = 1'b0;
                    draw_d         = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        game_over_d = (state_d != S_PLAY);
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            alive_d[i] = (lives_d[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            respawn_q      <= '0;
            alive_q        <= '1;
            game_over_q    <= 1'b1;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            draw_q         <= 1'b0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                lives_q[i] <= LIVES_INIT;
                score_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            respawn_q      <= respawn_d;
            alive_q        <= alive_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
            winner_valid_q <= winner_valid_d;
            draw_q         <= draw_d;
            lives_q        <= lives_d;
            score_q        <= score_d;
        end
    end

    always_comb begin : pack_outputs
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            lives[i*LIFE_W +: LIFE_W]   = lives_q[i];
            score[i*SCORE_W +: SCORE_W] = score_q[i];
        end
    end

    assign state        = state_q;
    assign game_over    = game_over_q;
    assign respawn      = respawn_q;
    assign alive        = alive_q;
    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;
    assign draw         = draw_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: 3 players, 2 lives, short timers,
// plus a 2-bit-score instance for saturation.
module tb_match_controller;

    logic        clk = 1'b0;
    logic        reset, game_on;
    logic [2:0]  hit, hit2;
    logic [5:0]  hit_by, hit_by2;

    logic        game_over, winner_valid, draw;
    logic [2:0]  respawn, alive, state;
    logic [5:0]  lives;
    logic [23:0] score;
    logic [1:0]  winner;

    logic        game_over2, winner_valid2, draw2;
    logic [2:0]  respawn2, alive2, state2;
    logic [5:0]  lives2, score2;
    logic [1:0]  winner2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    match_controller #(
        .NUM_PLAYERS(3), .LIVES(2), .LIFE_W(2), .SCORE_W(8),
        .COUNTDOWN_CYC(4), .ROUND_END_CYC(3)
    ) dut (
        .clk(clk), .reset(reset), .game_on(game_on), .hit(hit), .hit_by(hit_by),
        .game_over(game_over), .respawn(respawn), .alive(alive), .lives(lives),
        .score(score), .state(state), .winner(winner),
        .winner_valid(winner_valid), .draw(draw)
    );

    match_controller #(
        .NUM_PLAYERS(3), .LIVES(3), .LIFE_W(2), .SCORE_W(2),
        .COUNTDOWN_CYC(4), .ROUND_END_CYC(3)
    ) dut_sat (
        .clk(clk), .reset(reset), .game_on(game_on), .hit(hit2), .hit_by(hit_by2),
        .game_over(game_over2), .respawn(respawn2), .alive(alive2), .lives(lives2),
        .score(score2), .state(state2), .winner(winner2),
        .winner_valid(winner_valid2), .draw(draw2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_st(input int n, input logic [2:0] st);
        for (int k = 0; k < n; k++) begin
            tick();
            check("state_hold", 32'(state), 32'(st));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; game_on = 1'b0;
        hit = '0; hit_by = '0; hit2 = '0; hit_by2 = '0;
        tick(); tick();
        check("rst_state",  32'(state), 32'd0);
        check("rst_gover",  32'(game_over), 32'd1);
        check("rst_resp",   32'(respawn), 32'd0);
        check("rst_lives",  32'(lives), 32'b101010);
        check("rst_score",  32'(score), 32'd0);
        check("rst_wv",     32'(winner_valid), 32'd0);
        check("rst_draw",   32'(draw), 32'd0);
        check("rst_alive",  32'(alive), 32'b111);

        // start match
        reset = 1'b0; game_on = 1'b1;
        tick();
        check("start_state", 32'(state), 32'd1);
        check("start_resp",  32'(respawn), 32'b111);
        check("start_gover", 32'(game_over), 32'd1);
        tick_st(3, 3'd1);
        check("cd_resp_low", 32'(respawn), 32'd0);
        tick();
        check("play_state", 32'(state), 32'd2);
        check("play_gover", 32'(game_over), 32'd0);

        // player 0 hits player 1
        hit = 3'b010; hit_by = 6'b000000;
        tick(); hit = '0;
        check("h1_lives", 32'(lives), 32'b100110);
        check("h1_score", 32'(score), 32'h000001);
        check("h1_state", 32'(state), 32'd3);
        check("h1_gover", 32'(game_over), 32'd1);
        tick_st(2, 3'd3);
        tick();
        check("re1_state", 32'(state), 32'd1);
        check("re1_resp",  32'(respawn), 32'b111);

        // hits during countdown are ignored
        hit = 3'b111; hit_by = 6'b000000;
        tick(); hit = '0;
        check("cd_hit_lives", 32'(lives), 32'b100110);
        check("cd_hit_score", 32'(score), 32'h000001);
        check("cd_hit_state", 32'(state), 32'd1);
        tick_st(2, 3'd1);
        tick();
        check("play2_state", 32'(state), 32'd2);

        // mutual kill between 0 and 1
        hit = 3'b011; hit_by = 6'b000001;
        tick(); hit = '0;
        check("mut_lives", 32'(lives), 32'b100001);
        check("mut_score", 32'(score), 32'h000102);
        check("mut_alive", 32'(alive), 32'b101);
        check("mut_state", 32'(state), 32'd3);
        tick_st(2, 3'd3);
        tick();
        check("re2_state", 32'(state), 32'd1);
        check("re2_resp",  32'(respawn), 32'b101);
        tick_st(3, 3'd1);
        tick();
        check("play3_state", 32'(state), 32'd2);

        // self-hit
        hit = 3'b100; hit_by = 6'b100000;
        tick(); hit = '0;
        check("self_lives", 32'(lives), 32'b010001);
        check("self_score", 32'(score), 32'h000102);
        tick_st(2, 3'd3);
        tick();
        check("re3_resp", 32'(respawn), 32'b101);
        tick_st(3, 3'd1);
        tick();
        check("play4_state", 32'(state), 32'd2);

        // 2 kills 0; hit on dead player 1 must be ignored
        hit = 3'b011; hit_by = 6'b001010;
        tick(); hit = '0;
        check("kill0_lives", 32'(lives), 32'b010000);
        check("kill0_score", 32'(score), 32'h010102);
        tick_st(2, 3'd3);
        tick();
        check("win_state", 32'(state), 32'd4);
        check("win_idx",   32'(winner), 32'd2);
        check("win_valid", 32'(winner_valid), 32'd1);
        check("win_draw",  32'(draw), 32'd0);
        check("win_gover", 32'(game_over), 32'd1);
        check("win_resp",  32'(respawn), 32'd0);
        check("win_alive", 32'(alive), 32'b100);
        hit = 3'b100; hit_by = 6'b000000;
        tick(); hit = '0;
        check("mo_hold_state", 32'(state), 32'd4);
        check("mo_hold_lives", 32'(lives), 32'b010000);
        check("mo_hold_score", 32'(score), 32'h010102);
        game_on = 1'b0;
        tick();
        check("mo_exit_state", 32'(state), 32'd0);
        check("mo_exit_wv",    32'(winner_valid), 32'd0);
        check("mo_exit_lives", 32'(lives), 32'b010000);

        // draw match
        game_on = 1'b1;
        tick();
        check("d_start_state", 32'(state), 32'd1);
        check("d_start_lives", 32'(lives), 32'b101010);
        check("d_start_score", 32'(score), 32'd0);
        tick_st(3, 3'd1);
        tick();
        hit = 3'b111; hit_by = 6'b001001;
        tick(); hit = '0;
        check("d_h1_lives", 32'(lives), 32'b010101);
        check("d_h1_score", 32'(score), 32'h010101);
        tick_st(2, 3'd3);
        tick();
        check("d_re1_resp", 32'(respawn), 32'b111);
        tick_st(3, 3'd1);
        tick();
        hit = 3'b100; hit_by = 6'b000000;
        tick(); hit = '0;
        check("d_h2_lives", 32'(lives), 32'b000101);
        check("d_h2_score", 32'(score), 32'h010102);
        tick_st(2, 3'd3);
        tick();
        check("d_re2_resp", 32'(respawn), 32'b011);
        tick_st(3, 3'd1);
        tick();
        hit = 3'b011; hit_by = 6'b000001;
        tick(); hit = '0;
        check("d_h3_lives", 32'(lives), 32'd0);
        check("d_h3_score", 32'(score), 32'h010203);
        tick_st(2, 3'd3);
        tick();
        check("draw_state", 32'(state), 32'd4);
        check("draw_flag",  32'(draw), 32'd1);
        check("draw_wv",    32'(winner_valid), 32'd0);
        check("draw_alive", 32'(alive), 32'd0);
        game_on = 1'b0;
        tick();
        check("draw_exit", 32'(draw), 32'd0);

        // abort mid-PLAY
        game_on = 1'b1;
        tick();
        tick_st(3, 3'd1);
        tick();
        check("ab_play", 32'(state), 32'd2);
        game_on = 1'b0;
        tick();
        check("ab_state", 32'(state), 32'd0);
        check("ab_gover", 32'(game_over), 32'd1);

        // reset mid-match
        game_on = 1'b1;
        tick();
        tick_st(3, 3'd1);
        tick();
        hit = 3'b001; hit_by = 6'b000001;
        tick(); hit = '0;
        check("mr_score", 32'(score), 32'h000100);
        check("mr_state", 32'(state), 32'd3);
        reset = 1'b1;
        tick();
        check("mr_rst_state", 32'(state), 32'd0);
        check("mr_rst_score", 32'(score), 32'd0);
        check("mr_rst_lives", 32'(lives), 32'b101010);
        check("mr_rst_gover", 32'(game_over), 32'd1);
        reset = 1'b0;

        // saturation on the 2-bit score instance
        tick();
        for (int k = 0; k < 4; k++) tick();
        check("sat_play", 32'(state2), 32'd2);
        hit2 = 3'b110; hit_by2 = 6'b000000;
        tick(); hit2 = '0;
        check("sat_s1",    32'(score2), 32'b000010);
        check("sat_l1",    32'(lives2), 32'b101011);
        for (int k = 0; k < 7; k++) tick();
        check("sat_play2", 32'(state2), 32'd2);
        hit2 = 3'b110;
        tick(); hit2 = '0;
        check("sat_s2",    32'(score2), 32'b000011);
        check("sat_l2",    32'(lives2), 32'b010111);
        for (int k = 0; k < 7; k++) tick();
        hit2 = 3'b010;
        tick(); hit2 = '0;
        check("sat_s3",    32'(score2), 32'b000011);
        check("sat_l3",    32'(lives2), 32'b010011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
